pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel PWM generator for the switch/segment I/O wrapper. It extends the single-channel 8-bit PWM to `CHANNELS` independent outputs that share one period counter. Resolution is selectable at run time. Each channel has double-buffered duty registers, so a duty change takes effect only at a period boundary and never glitches an output. Center-aligned counting is an optional mode.

## Interface
- `CHANNELS`, default 4: number of PWM outputs, 1..16.
- `WIDTH`, default 8: maximum counter and duty width, 2..16.
- `BW`, derived as `$clog2(WIDTH+1)`: width of the `bits` port.
- `CW`, derived as `$clog2(CHANNELS)`, minimum 1: width of the channel select.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `ena`, in, 1: run enable.
- `bits`, in, BW: resolution. Edge-mode period is 2^bits cycles. Values 0 and 1 are treated as 1; values above WIDTH are clamped to WIDTH.
- `center`, in, 1: 1 selects center-aligned mode. It is ignored unless PWM_CENTER_EN is defined.
- `wr_en`, in, 1: duty write strobe.
- `wr_ch`, in, CW: channel index for the write. Writes with an index of CHANNELS or higher are dropped.
- `wr_duty`, in, WIDTH: duty value to write.
- `pwm_out`, out, CHANNELS: registered PWM outputs.
- `period_start`, out, 1: registered one-cycle pulse marking the first cycle of each period.

## Operation
- **Counter.** One shared `cnt` register, WIDTH bits. Define M = 2^eff_bits − 1.
- **Edge mode.** `cnt` counts 0, 1, …, M, then wraps to 0. The period is M+1 cycles.
- **Center mode.** `cnt` counts up 0→M, then down M→0, with `dir` flipping at each end. The values 0 and M each occur twice in a row. The period is 2(M+1) cycles.
- **Boundary cycle.** This is the cycle in which `cnt` = 0 and counting is upward (edge mode: every `cnt` = 0).
- **Duty buffering.** Each channel has a shadow register `sh[i]` and an active register `act[i]`, both WIDTH bits.
  - `wr_en` loads `sh[wr_ch]` ← `wr_duty` in any cycle, including while `ena` = 0.
  - In a boundary cycle with `ena` = 1, every `act[i]` ← `sh[i]`.
  - If a write lands in that same boundary cycle, the addressed `act` takes `wr_duty` directly (write-through).
- **Compare.** The next value of `pwm_out[i]` is (`ena` ∧ `cnt` < `act[i]`), compared at full WIDTH with no masking.
  - `act` = 0 gives a constant low output.
  - `act` ≥ M+1 gives a constant high output.
  - In edge mode the high time is `act` cycles per period.
  - In center mode the high time is 2·`act` cycles per period, centred on the `cnt` = 0 run.
- **Reconfiguration.** Effective bits and mode are registered every cycle as `cfg_q`.
  - If the incoming configuration differs from `cfg_q`, then on that clock edge: `cnt` ← 0, `dir` ← up, all `pwm_out` ← 0, and `period_start` ← 0.
  - The following cycle is a boundary cycle.
- **Enable.** With `ena` = 0, `cnt` and `dir` hold, `pwm_out` = 0, and `period_start` = 0. Counting resumes from the held value when `ena` returns to 1.

## Timing
- **Reset.** With `rst_n` low at a clock edge, the next state is:
  - `cnt` = 0, `dir` = up.
  - `pwm_out` = 0, `period_start` = 0.
  - All `sh` and `act` = 0.
  - `cfg_q` ← current inputs, so there is no spurious restart after reset.
- **After reset.** The first cycle after `rst_n` rises is a boundary cycle.
- **Reset mid-period.** Reset aborts the period immediately. Shadow values are lost.
- **Latency.** `pwm_out` and `period_start` are both registered from the current `cnt`/`act`, one cycle after the cycle they describe.
  - Consequently, a write reaches the output no earlier than 2 cycles after the next boundary.
- **Simultaneous events.**
  - Reset beats everything.
  - A reconfiguration beats a pending period wrap.
  - A write in the same cycle as a reconfiguration updates `sh` only; the `act` load happens at the following boundary.
- **Wrap arithmetic.** The comparison `cnt` == M uses the clamped effective bits. `cnt` never exceeds M.

## Configuration
- **`PWM_CENTER_EN` defined:** the `dir` register, up/down counting, and the `center` input are all live.
- **`PWM_CENTER_EN` undefined:**
  - `center` is ignored and the block is edge mode only.
  - `dir` is not synthesised.
  - `cfg_q` holds effective bits only.

## Test plan
- **Edge duty, basic.** Reset, CHANNELS=4, WIDTH=8, bits=3, write duty 3 to channel 0 and 0 to channel 1, run 24 cycles → `pwm_out[0]` is high 3 of every 8 cycles, `pwm_out[1]` stays 0, and `period_start` pulses every 8 cycles.
- **Double buffering.** Mid-period, write duty 6 to channel 0 → the current period keeps high=3; the next period has high=6. A write landing on the boundary cycle takes effect in that same period.
- **Duty extremes and clamping.**
  - bits=2, duty 4 and duty 255 → output constantly high.
  - bits=0 behaves as bits=1 (period 2).
  - bits=15 with WIDTH=8 behaves as bits=8 (period 256).
- **Reconfiguration and enable.**
  - Change bits 3→4 mid-period → outputs go 0 for one cycle, `cnt` restarts at 0, and the period becomes 16.
  - `ena` low for 5 cycles → outputs are 0 and the counter holds.
- **Reset mid-operation.** Assert `rst_n` low during an active high phase → the next cycle has all outputs 0 and `period_start` 0. All duties read back as 0, shown by outputs staying low after release.
- **Center mode (PWM_CENTER_EN defined).** center=1, bits=3, duty 2 → period 16, high for 4 consecutive cycles straddling the 0,0 turnaround, `period_start` once per 16 cycles.

Source files
------------

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control/status bundle for the multi-channel PWM block.
// The master side drives enable, resolution, mode and duty writes; the
// slave side (pwm_multi) returns the PWM outputs and the period marker.
interface pwm_multi_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                ena;
    logic [BW-1:0]       bits;
    logic                center;
    logic                wr_en;
    logic [CW-1:0]       wr_ch;
    logic [WIDTH-1:0]    wr_duty;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    modport master (
        output ena, bits, center, wr_en, wr_ch, wr_duty,
        input  pwm_out, period_start
    );

    modport slave (
        input  ena, bits, center, wr_en, wr_ch, wr_duty,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS independent PWM outputs sharing one period counter.
// Run-time resolution (clamped to 1..WIDTH bits), double-buffered duty
// registers that swap only at a period boundary, registered outputs.
// Optional feature macro: PWM_CENTER_EN enables center-aligned up/down
// counting via the center input; without it the block is edge mode only.
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    pwm_multi_if.slave bus
);
    localparam int BW = $clog2(WIDTH + 1);

    // Effective resolution: 0 and 1 both mean 1 bit, anything above WIDTH is WIDTH.
    logic [BW-1:0] eff_bits;

    // Resolution clamp.
    always_comb begin
        if (bus.bits <= BW'(1)) begin
            eff_bits = BW'(1);
        end else if (bus.bits > BW'(WIDTH)) begin
            eff_bits = BW'(WIDTH);
        end else begin
            eff_bits = bus.bits;
        end
    end

    // Top count value M = 2^eff_bits - 1; span needs one extra bit for eff_bits == WIDTH.
    logic [WIDTH:0]   span;
    logic [WIDTH-1:0] cnt_max;
    assign span    = {{WIDTH{1'b0}}, 1'b1} << eff_bits;
    assign cnt_max = WIDTH'(span - 1'b1);

    // Configuration word compared against its registered copy to detect a change.
`ifdef PWM_CENTER_EN
    localparam int CFGW = BW + 1;
    logic [CFGW-1:0] cfg_next;
    assign cfg_next = {bus.center, eff_bits};
`else
    localparam int CFGW = BW;
    logic [CFGW-1:0] cfg_next;
    assign cfg_next = eff_bits;
    // The mode input has no function in the edge-only build.
    logic unused_center;
    assign unused_center = bus.center;
`endif

    logic [CFGW-1:0]     cfg_q_reg;
    logic [WIDTH-1:0]    cnt_reg;
    logic [WIDTH-1:0]    cnt_next;
    logic                period_start_reg;
    logic                dir_up;
    logic                reconfig;
    logic                boundary;
    logic                load_act;
    logic                wr_valid;
    logic [CHANNELS-1:0] pwm_bits;

    assign reconfig = (cfg_next != cfg_q_reg);
    // A boundary is the first upward cycle at cnt == 0.
    assign boundary = (cnt_reg == '0) && dir_up;
    // A reconfiguration suppresses the active-duty swap; it happens at the next boundary instead.
    assign load_act = bus.ena && !reconfig && boundary;
    assign wr_valid = bus.wr_en && (int'(bus.wr_ch) < CHANNELS);

`ifdef PWM_CENTER_EN
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    dir_t dir_reg;
    dir_t dir_next;
    logic center_mode;

    assign center_mode = cfg_q_reg[BW];
    assign dir_up      = (dir_reg == DIR_UP);

    // Next count and direction: the ends (0 and M) each repeat once while dir flips.
    always_comb begin
        cnt_next = cnt_reg;
        dir_next = dir_reg;
        if (reconfig) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (bus.ena) begin
            if (!center_mode) begin
                cnt_next = (cnt_reg == cnt_max) ? '0 : cnt_reg + 1'b1;
            end else if (dir_reg == DIR_UP) begin
                if (cnt_reg == cnt_max) begin
                    dir_next = DIR_DOWN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                if (cnt_reg == '0) begin
                    dir_next = DIR_UP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
        end
    end

    // Direction state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_reg <= DIR_UP;
        end else begin
            dir_reg <= dir_next;
        end
    end
`else
    assign dir_up = 1'b1;

    // Next count: sawtooth 0..M, restart on reconfiguration, hold while disabled.
    always_comb begin
        cnt_next = cnt_reg;
        if (reconfig) begin
            cnt_next = '0;
        end else if (bus.ena) begin
            cnt_next = (cnt_reg == cnt_max) ? '0 : cnt_reg + 1'b1;
        end
    end
`endif

    // Shared counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Configuration snapshot and period marker; reset captures the live config so release is not a restart.
    always_ff @(posedge clk) begin
        cfg_q_reg <= cfg_next;
        if (!rst_n || reconfig || !bus.ena) begin
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= boundary;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] sh_reg;
            logic [WIDTH-1:0] act_reg;
            logic             pwm_reg;
            logic             wr_hit;

            assign wr_hit = wr_valid && (int'(bus.wr_ch) == gi);

            // Shadow duty: written any time, even while disabled.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sh_reg <= '0;
                end else if (wr_hit) begin
                    sh_reg <= bus.wr_duty;
                end
            end

            // Active duty: swapped in at a boundary, with a same-cycle write passing straight through.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    act_reg <= '0;
                end else if (load_act) begin
                    act_reg <= wr_hit ? bus.wr_duty : sh_reg;
                end
            end

            // Full-width compare of the current count against the active duty.
            always_ff @(posedge clk) begin
                if (!rst_n || reconfig) begin
                    pwm_reg <= 1'b0;
                end else begin
                    pwm_reg <= bus.ena && (cnt_reg < act_reg);
                end
            end

            assign pwm_bits[gi] = pwm_reg;
        end
    endgenerate

    assign bus.pwm_out      = pwm_bits;
    assign bus.period_start = period_start_reg;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: table-driven duty/resolution vectors plus hand sequences for
// double buffering, reconfiguration, enable, reset and (optionally) center mode.
// Every cycle is also checked against a scoreboard fed by a behavioural model.
module tb_pwm_multi;
    localparam int CH = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pwm_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

    pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          ps;
    } exp_t;

    typedef struct {
        int bits;
        int d0;
        int d1;
        int settle;
        int win;
        int hi0;
        int hi1;
        int ps;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_cnt;
    int m_up;
    int m_cfg;
    int m_sh[CH];
    int m_act[CH];

    // Observed activity counters
    int            hi_cnt[CH];
    int            ps_cnt;
    logic [CH-1:0] last_pwm;
    logic          last_ps;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Predict the outputs that the coming clock edge will produce.
    task automatic model_step();
        exp_t e;
        int   eff;
        int   mx;
        int   cfg;
        bit   wr_ok;
        eff = (int'(bus.bits) <= 1) ? 1 : ((int'(bus.bits) > W) ? W : int'(bus.bits));
        mx  = (1 << eff) - 1;
        cfg = eff;
`ifdef PWM_CENTER_EN
        if (bus.center) cfg += 100;
`endif
        e.pwm = '0;
        e.ps  = 1'b0;
        wr_ok = bus.wr_en && (int'(bus.wr_ch) < CH);
        if (!rst_n) begin
            m_cnt = 0;
            m_up  = 1;
            m_cfg = cfg;
            for (int i = 0; i < CH; i++) begin
                m_sh[i]  = 0;
                m_act[i] = 0;
            end
        end else if (cfg != m_cfg) begin
            m_cfg = cfg;
            m_cnt = 0;
            m_up  = 1;
            if (wr_ok) m_sh[int'(bus.wr_ch)] = int'(bus.wr_duty);
        end else begin
            if (wr_ok) m_sh[int'(bus.wr_ch)] = int'(bus.wr_duty);
            if (bus.ena) begin
                for (int i = 0; i < CH; i++) e.pwm[i] = (m_cnt < m_act[i]);
                e.ps = (m_cnt == 0) && (m_up == 1);
                if (e.ps) begin
                    for (int i = 0; i < CH; i++) m_act[i] = m_sh[i];
                end
                if (m_cfg >= 100) begin
                    if (m_up == 1) begin
                        if (m_cnt == mx) m_up = 0;
                        else m_cnt++;
                    end else begin
                        if (m_cnt == 0) m_up = 1;
                        else m_cnt--;
                    end
                end else begin
                    m_cnt = (m_cnt == mx) ? 0 : m_cnt + 1;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    // One clock: predict, clock, sample #1 later, compare, return at negedge.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        last_pwm = bus.pwm_out;
        last_ps  = bus.period_start;
        for (int i = 0; i < CH; i++) hi_cnt[i] += int'(last_pwm[i]);
        ps_cnt += int'(last_ps);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("pwm_out", int'(last_pwm), int'(e.pwm));
            chk("period_start", int'(last_ps), int'(e.ps));
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        ps_cnt = 0;
    endtask

    task automatic wr(input int ch, input int duty);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = 2'(ch);
        bus.wr_duty = 8'(duty);
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    // Advance until a period_start is observed, bounded.
    task automatic wait_ps(input string name);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            cycle();
            if (last_ps) found = 1'b1;
        end
        if (!found) chk(name, 0, 1);
    endtask

    initial begin
        int h;
        int first_k;
        bit found;

        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.bits    = 4'd3;
        bus.center  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_ch   = '0;
        bus.wr_duty = '0;
        m_cnt = 0;
        m_up  = 1;
        m_cfg = -1;
        for (int i = 0; i < CH; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        clr();

        //            bits d0   d1  settle win  hi0  hi1  ps
        vecs[0] = '{3,   3,   0,   20,   24,  9,   0,   3};
        vecs[1] = '{3,   6,   8,   20,   24,  18,  24,  3};
        vecs[2] = '{2,   4,   255, 12,   16,  16,  16,  4};
        vecs[3] = '{0,   1,   2,   8,    8,   4,   8,   4};
        vecs[4] = '{15,  100, 0,   520,  256, 100, 0,   1};
        vecs[5] = '{4,   5,   15,  40,   32,  10,  30,  2};

        // Reset state
        run(3);
        chk("reset_pwm_out", int'(bus.pwm_out), 0);
        chk("reset_period_start", int'(bus.period_start), 0);
        $display("reset: pwm_out=%b period_start=%b", bus.pwm_out, bus.period_start);
        rst_n = 1'b1;

        // Table-driven steady-state vectors
        for (int v = 0; v < 6; v++) begin
            bus.bits = 4'(vecs[v].bits);
            wr(0, vecs[v].d0);
            wr(1, vecs[v].d1);
            run(vecs[v].settle);
            clr();
            run(vecs[v].win);
            chk($sformatf("vec%0d_hi0", v), hi_cnt[0], vecs[v].hi0);
            chk($sformatf("vec%0d_hi1", v), hi_cnt[1], vecs[v].hi1);
            chk($sformatf("vec%0d_ps", v), ps_cnt, vecs[v].ps);
            $display("vec%0d: bits=%0d d0=%0d d1=%0d win=%0d hi0=%0d hi1=%0d ps=%0d",
                     v, vecs[v].bits, vecs[v].d0, vecs[v].d1, vecs[v].win,
                     hi_cnt[0], hi_cnt[1], ps_cnt);
        end

        // Double buffering: mid-period write waits for the next period
        bus.bits = 4'd3;
        wr(0, 3);
        wr(1, 0);
        run(20);
        wait_ps("db_wait_timeout");
        h = int'(last_pwm[0]);
        for (int k = 1; k < 8; k++) begin
            if (k == 3) wr(0, 6);
            else cycle();
            h += int'(last_pwm[0]);
        end
        chk("db_current_period_hi", h, 3);
        clr();
        run(8);
        chk("db_next_period_hi", hi_cnt[0], 6);
        chk("db_next_period_ps", ps_cnt, 1);
        // Write landing on the boundary cycle applies to that period
        clr();
        wr(0, 2);
        run(7);
        chk("db_boundary_write_hi", hi_cnt[0], 2);
        $display("double_buffer: cur=%0d next=6 boundary_write_hi=%0d", h, hi_cnt[0]);

        // Reconfiguration 3 -> 4 bits mid-period
        wait_ps("reconf_wait_timeout");
        run(2);
        bus.bits = 4'd4;
        cycle();
        chk("reconf_pwm_out", int'(last_pwm), 0);
        chk("reconf_period_start", int'(last_ps), 0);
        cycle();
        chk("reconf_boundary_ps", int'(last_ps), 1);
        clr();
        first_k = 0;
        for (int k = 1; k <= 32; k++) begin
            cycle();
            if (last_ps && first_k == 0) first_k = k;
        end
        chk("reconf_period_len", first_k, 16);
        chk("reconf_ps_count", ps_cnt, 2);
        $display("reconfig: new period=%0d ps_in_32=%0d", first_k, ps_cnt);

        // Enable low for 5 cycles
        bus.ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("ena_low_pwm_out", int'(last_pwm), 0);
            chk("ena_low_period_start", int'(last_ps), 0);
        end
        bus.ena = 1'b1;
        run(20);
        $display("enable: 5 idle cycles, resumed");

        // Reset during an active high phase
        wr(0, 9);
        wr(2, 12);
        run(40);
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            cycle();
            if (last_pwm[0]) found = 1'b1;
        end
        if (!found) chk("rst_wait_high_timeout", 0, 1);
        rst_n = 1'b0;
        cycle();
        chk("midrst_pwm_out", int'(last_pwm), 0);
        chk("midrst_period_start", int'(last_ps), 0);
        rst_n = 1'b1;
        clr();
        run(40);
        chk("post_reset_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        chk("post_reset_ps", ps_cnt, 3);
        $display("reset_mid: post-release highs=%0d ps=%0d",
                 hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], ps_cnt);

`ifdef PWM_CENTER_EN
        // Center-aligned: period 16, high 2*duty around the 0,0 turnaround
        bus.center = 1'b1;
        bus.bits   = 4'd3;
        wr(0, 2);
        run(40);
        clr();
        run(32);
        chk("center_hi0", hi_cnt[0], 8);
        chk("center_ps", ps_cnt, 2);
        $display("center: hi0=%0d ps=%0d over 32 cycles", hi_cnt[0], ps_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
